// File: rtl/result_collector_pkg.sv
// Shared types, defaults and the signature helper for the result collector.
package result_collector_pkg;

  localparam int unsigned DATA_W_DEF = 20;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } occ_state_e;

  // Rotate left by one, then fold in the new word.
  function automatic logic [DATA_W_DEF-1:0] sig_next(
    input logic [DATA_W_DEF-1:0] sig,
    input logic [DATA_W_DEF-1:0] data
  );
    return {sig[DATA_W_DEF-2:0], sig[DATA_W_DEF-1]} ^ data;
  endfunction

endpackage

// File: rtl/result_collector_if.sv
// Valid/ready handshake bundle for the collector input and output streams.
interface result_collector_if #(
  parameter int unsigned DATA_W = 20
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/result_collector_fifo.sv
// Small FIFO with level-tracked occupancy FSM; pointers wrap naturally.
module collector_fifo
  import result_collector_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   accept
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  occ_state_e        state, state_next;
  logic [LW-1:0]     level_next;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              pop;

  // Handshake outputs come only from registered state.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr];

  always_comb begin
    state_next = state;
    level_next = level;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          level_next = LW'(1);
          state_next = PARTIAL;
        end
      end
      PARTIAL: begin
        if (accept && !pop) begin
          level_next = level + LW'(1);
          if (level_next == LW'(DEPTH)) state_next = FULL;
        end else if (pop && !accept) begin
          level_next = level - LW'(1);
          if (level_next == '0) state_next = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          level_next = LW'(DEPTH - 1);
          state_next = PARTIAL;
        end
      end
      default: begin
        level_next = '0;
        state_next = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      level  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state <= state_next;
      level <= level_next;
      if (accept) wr_ptr <= wr_ptr + PW'(1);
      if (pop)    rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !rst) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/result_collector.sv
// Output stage: buffers datapath words and keeps a rotate-XOR signature and saturating count.
module result_collector
  import result_collector_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  result_collector_if.slave      bus,
  input  logic                   clear,
  output logic [DATA_W-1:0]      sig,
  output logic [CNT_W-1:0]       count,
  output logic [$clog2(DEPTH):0] level
);
  logic              accept;
  logic [DATA_W-1:0] sig_upd;

  collector_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .in_valid (bus.in_valid),
    .in_ready (bus.in_ready),
    .in_data  (bus.in_data),
    .out_valid(bus.out_valid),
    .out_ready(bus.out_ready),
    .out_data (bus.out_data),
    .level    (level),
    .accept   (accept)
  );

  // The package helper is fixed at the default width; other widths rotate inline.
  if (DATA_W == DATA_W_DEF) begin : g_sig_pkg
    assign sig_upd = sig_next(sig, bus.in_data);
  end else begin : g_sig_inline
    assign sig_upd = {sig[DATA_W-2:0], sig[DATA_W-1]} ^ bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sig   <= '0;
      count <= '0;
    end else if (clear) begin
      sig   <= accept ? bus.in_data : '0;
      count <= accept ? CNT_W'(1) : '0;
    end else if (accept) begin
      sig <= sig_upd;
      if (count != '1) count <= count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_result_collector.sv
// Directed self-checking bench for result_collector (DATA_W=20, DEPTH=4, CNT_W=16).
module tb_result_collector;
  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic [19:0] sig;
  logic [15:0] count;
  logic [2:0]  level;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [19:0] sig_m;
  logic [15:0] cnt_m;

  result_collector_if #(.DATA_W(20)) bus ();

  result_collector #(
    .DATA_W(20),
    .DEPTH (4),
    .CNT_W (16)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .clear(clear),
    .sig  (sig),
    .count(count),
    .level(level)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] rx(input logic [19:0] s, input logic [19:0] d);
    return {s[18:0], s[19]} ^ d;
  endfunction

  initial begin
    rst = 1'b1; clear = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_sig", 32'(sig), 0);
    chk("rst_count", 32'(count), 0);

    // Three pushes with the consumer stalled.
    bus.in_valid = 1'b1; bus.in_data = 20'h00001; step();
    chk("p1_sig", 32'(sig), 32'h00001);
    chk("p1_out_valid", 32'(bus.out_valid), 1);
    chk("p1_out_data", 32'(bus.out_data), 32'h00001);
    bus.in_data = 20'h00002; step();
    chk("p2_sig", 32'(sig), 32'h00000);
    bus.in_data = 20'h80000; step();
    chk("p3_sig", 32'(sig), 32'h80000);
    chk("p3_level", 32'(level), 3);
    chk("p3_count", 32'(count), 3);

    // Fill to DEPTH, then hold in_valid against a full FIFO.
    bus.in_data = 20'h00004; step();
    chk("p4_sig", 32'(sig), 32'h00005);
    chk("full_level", 32'(level), 4);
    chk("full_in_ready", 32'(bus.in_ready), 0);
    bus.in_data = 20'h00005; step();
    chk("hold_level", 32'(level), 4);
    chk("hold_count", 32'(count), 4);
    chk("hold_sig", 32'(sig), 32'h00005);
    bus.out_ready = 1'b1; step();
    bus.out_ready = 1'b0;
    chk("pop1_level", 32'(level), 3);
    chk("pop1_count", 32'(count), 4);
    chk("pop1_head", 32'(bus.out_data), 32'h00002);
    chk("pop1_in_ready", 32'(bus.in_ready), 1);
    step();
    chk("refill_level", 32'(level), 4);
    chk("refill_count", 32'(count), 5);
    chk("refill_sig", 32'(sig), 32'h0000F);
    step();
    chk("refill_hold_count", 32'(count), 5);

    // Drain in order.
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    chk("drain0", 32'(bus.out_data), 32'h00002); step();
    chk("drain1", 32'(bus.out_data), 32'h80000); step();
    chk("drain2", 32'(bus.out_data), 32'h00004); step();
    chk("drain3", 32'(bus.out_data), 32'h00005); step();
    chk("drain_level", 32'(level), 0);
    chk("drain_out_valid", 32'(bus.out_valid), 0);

    // Sustained streaming at level 1; pointers wrap twice.
    sig_m = 20'h0000F; cnt_m = 16'd5;
    bus.in_valid = 1'b1;
    for (int unsigned i = 0; i < 10; i++) begin
      bus.in_data = 20'(32'h100 + i);
      if (i > 0) chk("stream_order", 32'(bus.out_data), 32'h100 + i - 1);
      step();
      sig_m = rx(sig_m, 20'(32'h100 + i)); cnt_m++;
      chk("stream_level", 32'(level), 1);
    end
    bus.in_valid = 1'b0;
    chk("stream_last", 32'(bus.out_data), 32'h109);
    chk("stream_sig", 32'(sig), 32'(sig_m));
    chk("stream_count", 32'(count), 32'(cnt_m));
    step();
    chk("stream_empty", 32'(level), 0);

    // Clear coinciding with an accept, then clear alone.
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_data = 20'hAAAAA; step();
    clear = 1'b1; bus.in_data = 20'h12345; step();
    chk("clr_acc_sig", 32'(sig), 32'h12345);
    chk("clr_acc_count", 32'(count), 1);
    chk("clr_acc_level", 32'(level), 2);
    chk("clr_acc_head", 32'(bus.out_data), 32'hAAAAA);
    bus.in_valid = 1'b0; step();
    clear = 1'b0;
    chk("clr_sig", 32'(sig), 0);
    chk("clr_count", 32'(count), 0);
    chk("clr_level", 32'(level), 2);

    // Run the counter up to 0xFFFE at level 2, then past saturation.
    sig_m = '0; cnt_m = '0;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    for (int unsigned i = 0; i < 32'hFFFE; i++) begin
      bus.in_data = 20'(i);
      step();
      sig_m = rx(sig_m, 20'(i));
    end
    chk("pre_sat_count", 32'(count), 32'hFFFE);
    chk("pre_sat_level", 32'(level), 2);
    chk("pre_sat_sig", 32'(sig), 32'(sig_m));
    for (int unsigned i = 0; i < 3; i++) begin
      bus.in_data = 20'h3C3C3;
      step();
      chk("sat_count", 32'(count), 32'hFFFF);
    end

    // Reset mid-operation with an accept pending.
    bus.out_ready = 1'b0; rst = 1'b1; step();
    rst = 1'b0; bus.in_valid = 1'b0;
    chk("mid_rst_level", 32'(level), 0);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 0);
    chk("mid_rst_sig", 32'(sig), 0);
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/result_collector.md
# result_collector

Registered output stage that sits directly downstream of the combinational `top` datapath and captures its 20-bit `output_data` words. It accepts words over a valid/ready handshake and buffers them in a small FIFO for a downstream consumer. It also maintains a running rotate-XOR signature and a saturating word count, so a bench or host can check the datapath's output stream without storing it.

## Interface
Parameters:
- `DATA_W`, 20, word width; it matches the width of `top.output_data`.
- `DEPTH`, 4, number of FIFO entries. It must be a power of two and at least 2.
- `CNT_W`, 16, width of the saturating word counter.

Ports:
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst`  in  1  reset. Reset is synchronous and active-high.
- `in_valid`  in  1  upstream word is valid.
- `in_ready`  out  1  FIFO can accept a word; equals `!full`.
- `in_data`  in  DATA_W  word from `top.output_data`.
- `out_valid`  out  1  FIFO head is valid; equals `!empty`.
- `out_ready`  in  1  downstream accepts the head word.
- `out_data`  out  DATA_W  current FIFO head; driven from registered storage.
- `clear`  in  1  synchronous clear of `sig` and `count` only.
- `sig`  out  DATA_W  running signature.
- `count`  out  CNT_W  number of words accepted, saturating.
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Accept condition: `in_valid && in_ready`. Pop condition: `out_valid && out_ready`.
- Occupancy FSM states and transitions:
  - EMPTY (level 0):
    - accept → PARTIAL (or FULL when DEPTH==1, which is disallowed).
  - PARTIAL (0 < level < DEPTH):
    - accept only → level+1; enters FULL when level reaches DEPTH.
    - pop only → level−1; enters EMPTY when level reaches 0.
    - accept and pop together → level unchanged, state unchanged.
  - FULL (level == DEPTH):
    - `in_ready`=0, so no accept is possible.
    - pop → PARTIAL.
- Pointers:
  - Write and read pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH−1 to 0.
  - Occupancy is tracked by `level`, not by pointer comparison.
- `out_data` = `mem[rd_ptr]`. When the FIFO is empty, `out_data` holds the last value in that slot and carries no meaning.
- Signature update, on every accepted word: `sig <= {sig[DATA_W-2:0], sig[DATA_W-1]} ^ in_data`, i.e. rotate left by 1, then XOR.
- Count update: `count` increments by one per accepted word and saturates at all-ones.
- `clear` has priority over the signature and count updates:
  - `clear` without an accept → `sig`=0, `count`=0.
  - `clear` with an accept in the same cycle → `sig`=`in_data`, `count`=1.
- `clear` does not affect the FIFO, `level`, or the handshake outputs.
- Datapath is pure unsigned arithmetic; there is no sign extension anywhere.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `level`=0, `sig`=0, `count`=0, both pointers 0.
  - `out_data` after reset is `mem[0]`. Storage is not reset and is don't-care while `out_valid`=0.
- A `rst` asserted mid-operation discards all buffered words on the next edge. Any accept or pop in that cycle is ignored.
- Latency:
  - A word accepted at edge N into an empty FIFO appears on `out_data` with `out_valid`=1 after edge N.
  - There is no combinational path from `in_data` or `in_valid` to `out_*`.
- `in_ready` is registered-state-derived only (from `level`). It does not depend on `out_ready` in the same cycle, so there is no pass-through while full.
- `sig` and `count` reflect an accepted word on the cycle after the accept edge.
- Throughput: one accept and one pop per cycle, sustained, whenever 0 < level < DEPTH.
- Upstream rule: `in_data` must be stable while `in_valid`=1 and `in_ready`=0. The block does not check this.

## Structure
- Package `result_collector_pkg` holds:
  - `DATA_W_DEF`=20 and `CNT_W_DEF`=16.
  - The `occ_state_e` enum: EMPTY, PARTIAL, FULL.
  - Function `sig_next(sig, data)` implementing the rotate-XOR.
- Sub-module `collector_fifo` holds the storage array, the pointers, `level`, and the FSM.
- The top level instantiates `collector_fifo` and adds the signature and counter logic.

## Test plan
- Reset, then push 0x00001, 0x00002, 0x80000 with `out_ready`=0:
  - `level`=3, `count`=3.
  - `sig` after each accept: 0x00001, then 0x00000, then 0x80000.
- Fill to DEPTH=4, hold `in_valid`=1:
  - `in_ready`=0, `level` stays 4, `count` stays 4.
  - Assert `out_ready` for one cycle: 1 pop, then exactly 1 accept on the following cycle.
- Stream 10 words with `in_valid`=`out_ready`=1 continuously:
  - `level` stays at 1 after the first cycle.
  - Output order equals input order; pointers wrap twice.
- Assert `clear` together with an accept of 0x12345 → `sig`=0x12345, `count`=1. FIFO contents are unchanged.
- Preload `count` to 0xFFFE by pushing and draining, then accept 3 more words → `count`=0xFFFF and holds.
- Assert `rst` with `level`=2 and `in_valid`=1 → next cycle `level`=0, `out_valid`=0, `sig`=0, `count`=0.
